// File: rtl/alu_pkg.sv
// Shared encodings for the ALU/mul-div execute stage:
// control codes, R-type function codes, alu_op values and FSM states.
package alu_pkg;

    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_MULT = 4'b0011;
    localparam logic [3:0] CTL_DIV  = 4'b0100;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;
    localparam logic [3:0] CTL_MFHI = 4'b1000;
    localparam logic [3:0] CTL_MFLO = 4'b1001;
    localparam logic [3:0] CTL_ILL  = 4'b1111;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_SLT   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

endpackage

// File: rtl/alu_muldiv_exec_dec.sv
// Combinational alu_op + func -> 4-bit ALU control decoder,
// flagging R-type function codes that have no mapping.
module alu_ctl_dec
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] func,
    output logic [3:0] ctl,
    output logic       illegal
);

    always_comb begin
        ctl     = CTL_ILL;
        illegal = 1'b0;
        unique case (1'b1)
            (alu_op == OP_ADD): ctl = CTL_ADD;
            (alu_op == OP_SUB): ctl = CTL_SUB;
            (alu_op == OP_SLT): ctl = CTL_SLT;
            default: begin
                unique case (func)
                    F_ADD:   ctl = CTL_ADD;
                    F_SUB:   ctl = CTL_SUB;
                    F_AND:   ctl = CTL_AND;
                    F_OR:    ctl = CTL_OR;
                    F_SLT:   ctl = CTL_SLT;
                    F_MULT:  ctl = CTL_MULT;
                    F_DIV:   ctl = CTL_DIV;
                    F_MFHI:  ctl = CTL_MFHI;
                    F_MFLO:  ctl = CTL_MFLO;
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_muldiv_exec.sv
// EX stage: registered ALU ops plus iterative mult/div with HI/LO.
// Define ALU_SIGNED_MULDIV_EN for two's-complement mult/div.
module alu_muldiv_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef ALU_SIGNED_MULDIV_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic [3:0]         ctl;
    logic               dec_ill;
    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, mul_nxt, div_nxt, fin;
    logic [WIDTH-1:0]   opnd, res_nxt, ua, ub, da, dq, dr;
    logic [WIDTH:0]     mul_sum, div_sh, div_tr;
    logic               accept, last, sa, sb, bz, take;
    logic               neg_lo, neg_hi;

    alu_ctl_dec u_dec (
        .alu_op  (alu_op),
        .func    (func),
        .ctl     (ctl),
        .illegal (dec_ill)
    );

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign last     = (state != IDLE) && (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept && ctl == CTL_MULT)     state_nxt = MUL;
                else if (accept && ctl == CTL_DIV) state_nxt = DIV;
            end
            MUL, DIV: if (last) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Magnitudes are iterated; a zero divisor keeps the raw dividend.
    always_comb begin
        sa = SGN && opa[WIDTH-1];
        sb = SGN && opb[WIDTH-1];
        bz = (opb == '0);
        ua = sa ? -opa : opa;
        ub = sb ? -opb : opb;
        da = bz ? opa : ua;
    end

    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, opnd} : '0);
        mul_nxt = {mul_sum, acc[WIDTH-1:1]};
        div_sh  = acc[2*WIDTH-1:WIDTH-1];
        div_tr  = div_sh - {1'b0, opnd};
        take    = (div_sh >= {1'b0, opnd});
        div_nxt = take ? {div_tr[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                       : {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        dq      = div_nxt[WIDTH-1:0];
        dr      = div_nxt[2*WIDTH-1:WIDTH];
        if (state == MUL)
            fin = neg_lo ? -mul_nxt : mul_nxt;
        else
            fin = {neg_hi ? -dr : dr, neg_lo ? -dq : dq};
    end

    always_comb begin
        res_nxt = '0;
        unique case (1'b1)
            (ctl == CTL_ADD):  res_nxt = opa + opb;
            (ctl == CTL_SUB):  res_nxt = opa - opb;
            (ctl == CTL_AND):  res_nxt = opa & opb;
            (ctl == CTL_OR):   res_nxt = opa | opb;
            (ctl == CTL_SLT):
                res_nxt = WIDTH'($signed(opa) < $signed(opb));
            (ctl == CTL_MFHI): res_nxt = hi;
            (ctl == CTL_MFLO): res_nxt = lo;
            default:           res_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            result    <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            alu_ctl   <= 4'b0000;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                alu_ctl <= ctl;
                if (ctl == CTL_MULT) begin
                    cnt    <= CNT_W'(WIDTH);
                    acc    <= {{WIDTH{1'b0}}, ub};
                    opnd   <= ua;
                    neg_lo <= sa ^ sb;
                    neg_hi <= sa ^ sb;
                end else if (ctl == CTL_DIV) begin
                    cnt    <= CNT_W'(WIDTH);
                    acc    <= {{WIDTH{1'b0}}, da};
                    opnd   <= ub;
                    neg_lo <= !bz && (sa ^ sb);
                    neg_hi <= !bz && sa;
                end else begin
                    result    <= res_nxt;
                    zero      <= (res_nxt == '0);
                    illegal   <= dec_ill;
                    out_valid <= 1'b1;
                end
            end else if (state != IDLE) begin
                cnt <= cnt - CNT_W'(1);
                acc <= (state == MUL) ? mul_nxt : div_nxt;
                if (last) begin
                    hi        <= fin[2*WIDTH-1:WIDTH];
                    lo        <= fin[WIDTH-1:0];
                    result    <= fin[WIDTH-1:0];
                    zero      <= (fin[WIDTH-1:0] == '0);
                    illegal   <= 1'b0;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule
